// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the divider bank.
// Divisor width default, reset divisor, minimum divisor, high-time and clamp.
package clk_div_pkg;

  localparam int unsigned DIV_W       = 26;
  localparam int unsigned DIV_DEFAULT = 50000000;
  localparam int unsigned MIN_DIV     = 2;

  function automatic logic [31:0] hi_cycles(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: divisor write port of the divider bank.
// master drives the write, slave (the bank) receives it.
interface clk_div_bank_if #(
  parameter int N_CH = 4,
  parameter int W    = 26
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic          div_wr;
  logic [CW-1:0] div_ch;
  logic [W-1:0]  div_data;

  modport master (output div_wr, div_ch, div_data);
  modport slave  (input  div_wr, div_ch, div_data);

endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divider with shadow/active divisor.
// Divisor swaps only at period boundaries so the output never glitches.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          W           = DIV_W,
  parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  input  logic         sync_i,
  output logic         clk_o,
  output logic         tick_o
);

  logic [W-1:0] s_q, s_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] p_q, p_d;
  logic         tick_q, tick_d;
  logic         clk_q, clk_d;
  logic         wrap;
  logic         hi;

  // next-state: shadow write, wrap/count when enabled, idle when not
  always_comb begin
    s_d    = s_q;
    d_d    = d_q;
    p_d    = p_q;
    tick_d = 1'b0;
    clk_d  = 1'b0;
    wrap   = (p_q == d_q - W'(1)) || sync_i;
    hi     = (32'(p_q) + 32'd1) < hi_cycles(32'(d_q));
    if (wr_i) s_d = W'(clamp_div(32'(data_i)));
    if (en_i) begin
      if (wrap) begin
        d_d    = s_q;
        p_d    = '0;
        tick_d = 1'b1;
        clk_d  = 1'b1;
      end else begin
        p_d    = p_q + W'(1);
        clk_d  = hi;
      end
    end else begin
      p_d = d_q - W'(1);
    end
  end

  // state and registered outputs; reset parks at end-of-period
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s_q    <= W'(DEFAULT_DIV);
      d_q    <= W'(DEFAULT_DIV);
      p_q    <= W'(DEFAULT_DIV) - W'(1);
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      d_q    <= d_d;
      p_q    <= p_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent dividers behind one divisor write port.
// Define CLKDIV_SYNC_EN to add sync_i, which restarts all enabled channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          W           = DIV_W,
  parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en,
  clk_div_bank_if.slave   wr,
`ifdef CLKDIV_SYNC_EN
  input  logic            sync_i,
`endif
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_hit;

    assign wr_hit = wr.div_wr && (int'(wr.div_ch) == i);

    clk_div_channel #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .en_i   (en[i]),
      .wr_i   (wr_hit),
      .data_i (wr.div_data),
      .sync_i (sync),
      .clk_o  (clk_out[i]),
      .tick_o (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and random stimulus against a period model.
// Model tracks run/position per channel and derives outputs arithmetically.
module tb_clk_div_bank;

  localparam int N   = 5;
  localparam int WW  = 8;
  localparam int DEF = 4;
  localparam int CW  = 3;

  logic         sysclk = 1'b0;
  logic         rst_n;
  logic [N-1:0] en;
  logic         sync_i;
  logic [N-1:0] clk_out;
  logic [N-1:0] tick;

  int n_chk  = 0;
  int n_fail = 0;

  int m_s[N];
  int m_d[N];
  int m_pos[N];
  bit m_run[N];
  logic [N-1:0] x_tick;
  logic [N-1:0] x_clk;

  clk_div_bank_if #(.N_CH(N), .W(WW)) bus ();

  clk_div_bank #(
    .N_CH        (N),
    .W           (WW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .en      (en),
    .wr      (bus),
`ifdef CLKDIV_SYNC_EN
    .sync_i  (sync_i),
`endif
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit sy;
    int ns;
`ifdef CLKDIV_SYNC_EN
    sy = sync_i;
`else
    sy = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_s[i] = DEF; m_d[i] = DEF; m_run[i] = 0; m_pos[i] = 0;
        x_tick[i] = 0; x_clk[i] = 0;
        continue;
      end
      ns = m_s[i];
      if (bus.div_wr && int'(bus.div_ch) == i)
        ns = (bus.div_data < 2) ? 2 : int'(bus.div_data);
      if (en[i]) begin
        if (!m_run[i] || sy || m_pos[i] == m_d[i] - 1) begin
          m_d[i] = m_s[i]; m_pos[i] = 0; m_run[i] = 1;
          x_tick[i] = 1;
        end else begin
          m_pos[i]++;
          x_tick[i] = 0;
        end
        x_clk[i] = m_pos[i] < (m_d[i] + 1) / 2;
      end else begin
        m_run[i] = 0; x_tick[i] = 0; x_clk[i] = 0;
      end
      m_s[i] = ns;
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(x_tick[i]));
      chk($sformatf("clk%0d", i), 32'(clk_out[i]), 32'(x_clk[i]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr_div(input int ch, input int data);
    bus.div_wr = 1'b1;
    bus.div_ch = CW'(ch);
    bus.div_data = WW'(data);
    step();
    bus.div_wr = 1'b0;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    en = '0;
    sync_i = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_ch = '0;
    bus.div_data = '0;
    run(2);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clk", 32'(clk_out), 32'd0);

    rst_n = 1'b1;
    en = '1;
    step();
    chk("first_tick", 32'(tick), 32'h1f);
    chk("first_clk", 32'(clk_out), 32'h1f);
    run(3);
    chk("d4_pat_c4", 32'(clk_out[0]), 32'd0);
    step();
    chk("d4_tick_c5", 32'(tick[0]), 32'd1);
    run(2);

    wr_div(1, 3);
    run(12);
    wr_div(2, 0);
    wr_div(7, 9);
    run(10);

    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (m_run[0] && m_pos[0] == m_d[0] - 1) ok = 1;
      else step();
    end
    chk("wrap_align", 32'(ok), 32'd1);
    wr_div(0, 6);
    run(15);

    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (x_clk[3]) ok = 1;
      else step();
    end
    chk("hi_align", 32'(ok), 32'd1);
    en[3] = 1'b0;
    step();
    chk("drop_clk3", 32'(clk_out[3]), 32'd0);
    en[3] = 1'b1;
    step();
    chk("reen_tick3", 32'(tick[3]), 32'd1);
    chk("reen_clk3", 32'(clk_out[3]), 32'd1);
    run(6);

`ifdef CLKDIV_SYNC_EN
    wr_div(0, 5);
    wr_div(1, 7);
    run(3);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    chk("sync_tick", 32'(tick[1:0]), 32'd3);
    run(20);
    rst_n = 1'b0;
    sync_i = 1'b1;
    step();
    chk("rst_sync_tick", 32'(tick), 32'd0);
    chk("rst_sync_clk", 32'(clk_out), 32'd0);
    rst_n = 1'b1;
    sync_i = 1'b0;
    run(4);
`endif

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      bus.div_wr = ($urandom_range(0, 7) == 0);
      bus.div_ch = CW'($urandom_range(0, 7));
      bus.div_data = WW'($urandom_range(0, 10));
`ifdef CLKDIV_SYNC_EN
      sync_i = ($urandom_range(0, 49) == 0);
`endif
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
